// File: rtl/axi_r_burst_buffer.sv
// rtl/axi_r_burst_buffer.sv - AXI R-channel FIFO with store-and-forward release and oversize-burst drain
module axi_r_burst_buffer #(
   parameter int ID_WIDTH     = 4,
   parameter int DATA_WIDTH   = 64,
   parameter int USER_WIDTH   = 6,
   parameter int BUFFER_DEPTH = 8,
   parameter int AF_THRESH    = BUFFER_DEPTH - 2,
   parameter int CNT_WIDTH    = $clog2(BUFFER_DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  test_en_i,
   input  logic                  sf_en_i,
   input  logic                  slave_valid_i,
   input  logic [DATA_WIDTH-1:0] slave_data_i,
   input  logic [1:0]            slave_resp_i,
   input  logic [USER_WIDTH-1:0] slave_user_i,
   input  logic [ID_WIDTH-1:0]   slave_id_i,
   input  logic                  slave_last_i,
   output logic                  slave_ready_o,
   output logic                  master_valid_o,
   output logic [DATA_WIDTH-1:0] master_data_o,
   output logic [1:0]            master_resp_o,
   output logic [USER_WIDTH-1:0] master_user_o,
   output logic [ID_WIDTH-1:0]   master_id_o,
   output logic                  master_last_o,
   input  logic                  master_ready_i,
   output logic [CNT_WIDTH-1:0]  fill_level_o,
   output logic [CNT_WIDTH-1:0]  burst_cnt_o,
   output logic                  almost_full_o
);

   localparam int PTR_W   = $clog2(BUFFER_DEPTH);
   localparam int ENTRY_W = DATA_WIDTH + 2 + USER_WIDTH + ID_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(BUFFER_DEPTH);
   localparam logic [CNT_WIDTH-1:0] AF_CNT   = CNT_WIDTH'(AF_THRESH);

   logic [ENTRY_W-1:0]   mem_q [BUFFER_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0] count_q, count_d, burst_cnt_q, burst_cnt_d;
   logic                 drain_q, drain_d, sf_q, sf_d, af_q, af_d;
   logic                 push, pop, push_last, pop_last;
   logic                 unused_test_en;

   assign unused_test_en = test_en_i;

   assign {master_data_o, master_resp_o, master_user_o, master_id_o, master_last_o} = mem_q[rd_ptr_q];

   assign slave_ready_o  = (count_q != FULL_CNT);
   // In store-and-forward, release only once a whole burst is held, or when draining an oversize one.
   assign master_valid_o = (count_q != '0) && (!sf_q || (burst_cnt_q != '0) || drain_q);

   assign push      = slave_valid_i && slave_ready_o;
   assign pop       = master_valid_o && master_ready_i;
   assign push_last = push && slave_last_i;
   assign pop_last  = pop && master_last_o;

   assign fill_level_o  = count_q;
   assign burst_cnt_o   = burst_cnt_q;
   assign almost_full_o = af_q;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      burst_cnt_d = burst_cnt_q;
      drain_d     = drain_q;
      sf_d        = sf_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      if (push && !pop)      count_d = count_q + CNT_WIDTH'(1);
      else if (!push && pop) count_d = count_q - CNT_WIDTH'(1);

      if (push_last && !pop_last)      burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
      else if (!push_last && pop_last) burst_cnt_d = burst_cnt_q - CNT_WIDTH'(1);

      // A full buffer with no complete burst can never satisfy store-and-forward; fall back to cut-through.
      if (pop_last)
         drain_d = 1'b0;
      else if (sf_q && (count_q == FULL_CNT) && (burst_cnt_q == '0))
         drain_d = 1'b1;

      if ((count_q == '0) && !push) sf_d = sf_en_i;

      af_d = (count_d >= AF_CNT);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         burst_cnt_q <= '0;
         drain_q     <= 1'b0;
         sf_q        <= 1'b0;
         af_q        <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         burst_cnt_q <= burst_cnt_d;
         drain_q     <= drain_d;
         sf_q        <= sf_d;
         af_q        <= af_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push)
         mem_q[wr_ptr_q] <= {slave_data_i, slave_resp_i, slave_user_i, slave_id_i, slave_last_i};
   end

endmodule
